// File: rtl/memory_arbiter.sv
// Two-client round-robin arbiter in front of a single-port RAM.
// Each transaction runs IDLE -> ACCESS -> SETTLE -> DONE, with the RAM bus held stable for two cycles.
module memory_arbiter #(
  parameter int addrBits = 16,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aReq,
  input  logic                aWrite,
  input  logic [addrBits-1:0] aAddress,
  input  logic [dataBits-1:0] aDataIn,
  output logic                aAck,
  output logic [dataBits-1:0] aDataOut,
  input  logic                bReq,
  input  logic                bWrite,
  input  logic [addrBits-1:0] bAddress,
  input  logic [dataBits-1:0] bDataIn,
  output logic                bAck,
  output logic [dataBits-1:0] bDataOut,
  input  logic [dataBits-1:0] ramDataOut,
  output logic                ramReadWriteMode,
  output logic [addrBits-1:0] ramAddress,
  output logic [dataBits-1:0] ramDataIn,
  output logic                busy
);

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, SETTLE, DONE} state_t;

  state_t              r_state;
  logic                r_grantB;
  logic                r_lastGrantB;
  logic                r_write;
  logic [addrBits-1:0] r_addr;
  logic [dataBits-1:0] r_data;

  logic w_pickB;
  logic w_onBus;

  // On a tie the client that was not granted last time wins.
  assign w_pickB = bReq && (!aReq || !r_lastGrantB);
  assign w_onBus = (r_state == ACCESS) || (r_state == SETTLE);

  // The RAM only ever sees the latched transaction, and only while it is on the bus.
  assign ramAddress       = w_onBus ? r_addr : '0;
  assign ramDataIn        = w_onBus ? r_data : '0;
  assign ramReadWriteMode = (w_onBus && r_write) ? RAM_WRITE : RAM_READ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grantB     <= 1'b0;
      r_lastGrantB <= 1'b1;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      aAck         <= 1'b0;
      bAck         <= 1'b0;
      aDataOut     <= '0;
      bDataOut     <= '0;
      busy         <= 1'b0;
    end else begin
      aAck <= 1'b0;
      bAck <= 1'b0;
      case (r_state)
        IDLE: begin
          if (aReq || bReq) begin
            r_grantB     <= w_pickB;
            r_lastGrantB <= w_pickB;
            r_write      <= w_pickB ? bWrite   : aWrite;
            r_addr       <= w_pickB ? bAddress : aAddress;
            r_data       <= w_pickB ? bDataIn  : aDataIn;
            busy         <= 1'b1;
            r_state      <= ACCESS;
          end
        end
        ACCESS: r_state <= SETTLE;
        SETTLE: begin
          // Read data is valid in the second bus cycle, so capture it here.
          if (!r_write) begin
            if (r_grantB) bDataOut <= ramDataOut;
            else          aDataOut <= ramDataOut;
          end
          aAck    <= !r_grantB;
          bAck    <= r_grantB;
          r_state <= DONE;
        end
        DONE: begin
          // Requests are deliberately ignored here so a held Req is not serviced twice.
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a transaction-level model predicts grants, bus activity,
// acks and read data; a negedge monitor compares every cycle against the queued prediction.
module tb_memory_arbiter;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        aReq, aWrite, bReq, bWrite;
  logic [15:0] aAddress, aDataIn, bAddress, bDataIn;
  logic        aAck, bAck, busy, ramReadWriteMode;
  logic [15:0] aDataOut, bDataOut, ramDataOut, ramAddress, ramDataIn;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_arbiter #(.addrBits(16), .dataBits(16)) dut (
    .clk(clk), .reset(reset),
    .aReq(aReq), .aWrite(aWrite), .aAddress(aAddress), .aDataIn(aDataIn),
    .aAck(aAck), .aDataOut(aDataOut),
    .bReq(bReq), .bWrite(bWrite), .bAddress(bAddress), .bDataIn(bDataIn),
    .bAck(bAck), .bDataOut(bDataOut),
    .ramDataOut(ramDataOut), .ramReadWriteMode(ramReadWriteMode),
    .ramAddress(ramAddress), .ramDataIn(ramDataIn), .busy(busy)
  );

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = (16'(i) * 16'h9E37) ^ 16'h5A5A;
    if (i == 16'h0010) v = 16'hBEEF;
    return v;
  endfunction

  // Bench-side RAM: asynchronous read, write on the clock edge while mode is WRITE.
  logic [15:0] ram [0:65535];
  assign ramDataOut = ram[ramAddress];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ramReadWriteMode == RAM_WRITE) ram[ramAddress] <= ramDataIn;
    end
  end

  typedef struct {
    bit          cl;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    int          g;
  } txn_t;
  txn_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, each occupying 4 cycles from its sampling cycle.
  logic [15:0] mem [0:65535];
  initial begin
    int          next_free;
    bit          lastB;
    logic [15:0] lastA_dout, lastB_dout;
    txn_t        t;
    for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
    next_free = 0; lastB = 1'b1; lastA_dout = '0; lastB_dout = '0;
    forever begin
      @(posedge clk);
      if (reset !== 1'b1) begin
        q.delete();
        next_free = cyc + 1;
        lastB = 1'b1; lastA_dout = '0; lastB_dout = '0;
      end else if (cyc >= next_free && (aReq || bReq)) begin
        t.cl    = (aReq && bReq) ? !lastB : bReq;
        t.wr    = t.cl ? bWrite   : aWrite;
        t.addr  = t.cl ? bAddress : aAddress;
        t.wdata = t.cl ? bDataIn  : aDataIn;
        if (t.wr) mem[t.addr] = t.wdata;
        else if (t.cl) lastB_dout = mem[t.addr];
        else lastA_dout = mem[t.addr];
        t.dout = t.cl ? lastB_dout : lastA_dout;
        t.g    = cyc;
        lastB  = t.cl;
        next_free = cyc + 4;
        q.push_back(t);
      end
    end
  end

  // Monitor: every cycle, compare acks, busy and the RAM bus against the pending transaction.
  initial begin
    int   c;
    bit   act, ea, eb, onbus, ebusy;
    txn_t f;
    forever begin
      @(negedge clk);
      if (started) begin
        c   = cyc;
        act = q.size() > 0;
        if (act) f = q[0];
        ea    = act && (c == f.g + 3) && !f.cl;
        eb    = act && (c == f.g + 3) && f.cl;
        onbus = act && ((c == f.g + 1) || (c == f.g + 2));
        ebusy = act && (c >= f.g + 1) && (c <= f.g + 3);
        chk("aAck", 32'(aAck), 32'(ea));
        chk("bAck", 32'(bAck), 32'(eb));
        chk("busy", 32'(busy), 32'(ebusy));
        chk("ramReadWriteMode", 32'(ramReadWriteMode), 32'((onbus && f.wr) ? RAM_WRITE : RAM_READ));
        chk("ramAddress", 32'(ramAddress), onbus ? 32'(f.addr) : 32'd0);
        chk("ramDataIn", 32'(ramDataIn), onbus ? 32'(f.wdata) : 32'd0);
        if (ea) chk("aDataOut", 32'(aDataOut), 32'(f.dout));
        if (eb) chk("bDataOut", 32'(bDataOut), 32'(f.dout));
        if (act && c >= f.g + 3) void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input bit cl, input logic rq, input logic wr,
                         input logic [15:0] ad, input logic [15:0] dt);
    if (cl) begin
      bReq = rq; bWrite = wr; bAddress = ad; bDataIn = dt;
    end else begin
      aReq = rq; aWrite = wr; aAddress = ad; aDataIn = dt;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom_range(31));
    endcase
  endfunction

  // Raise a request and hold it until this client's Ack (bounded); optionally scramble the
  // request fields while waiting, and optionally leave Req high afterwards.
  task automatic do_txn(input bit cl, input logic wr, input logic [15:0] ad, input logic [15:0] dt,
                        input bit scramble, input bit keep);
    bit ok;
    ok = 1'b0;
    set_req(cl, 1'b1, wr, ad, dt);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if ((cl ? bAck : aAck) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (scramble && $urandom_range(3) == 0)
        set_req(cl, 1'b1, 1'($urandom_range(1)), rand_addr(), 16'($urandom));
    end
    chk("txn_timeout", 32'(ok), 32'd1);
    if (!keep) set_req(cl, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic rand_client(input bit cl);
    int mode;
    for (int it = 0; it < 60; it++) begin
      mode = int'($urandom_range(3));
      if (mode == 0) begin
        // Impatient client: may drop Req before (or without) being serviced.
        set_req(cl, 1'b1, 1'($urandom_range(1)), rand_addr(), 16'($urandom));
        idle(int'($urandom_range(6, 1)));
        set_req(cl, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle(int'($urandom_range(5)));
      end else begin
        do_txn(cl, 1'($urandom_range(1)), rand_addr(), 16'($urandom), mode == 1, 1'b0);
        idle(int'($urandom_range(2)));
      end
    end
  endtask

  initial begin
    int  cnt;
    bit  ok;
    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1 started = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_aAck", 32'(aAck), 32'd0);
    chk("rst_bAck", 32'(bAck), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_aDataOut", 32'(aDataOut), 32'd0);
    chk("rst_bDataOut", 32'(bDataOut), 32'd0);
    chk("rst_mode", 32'(ramReadWriteMode), 32'(RAM_READ));
    chk("rst_ramAddress", 32'(ramAddress), 32'd0);
    chk("rst_ramDataIn", 32'(ramDataIn), 32'd0);
    reset = 1'b1;
    idle(2);

    // Single read, single write to the top address, read-back of that address.
    do_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    idle(2);
    do_txn(1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
    idle(1);
    do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    chk("readback_ffff", 32'(aDataOut), 32'h1234);
    idle(2);

    // Contention with both Reqs held continuously.
    fork
      begin
        for (int i = 0; i < 4; i++) do_txn(1'b0, 1'b0, 16'(16'h0100 + i), 16'h0000, 1'b0, i < 3);
      end
      begin
        for (int j = 0; j < 4; j++) do_txn(1'b1, 1'b0, 16'(16'h0200 + j), 16'h0000, 1'b0, j < 3);
      end
    join
    idle(2);

    // Held request for 12 cycles yields exactly three transactions.
    cnt = 0;
    set_req(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (aAck === 1'b1) cnt++;
    end
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (aAck === 1'b1) cnt++;
    end
    chk("held_ack_count", 32'(cnt), 32'd3);

    // Reset during SETTLE of a B write.
    ok = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 16'h0040, 16'hCAFE);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midrst_grant", 32'(ok), 32'd1);
    idle(1);
    reset = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(1);
    chk("midrst_bAck", 32'(bAck), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mode", 32'(ramReadWriteMode), 32'(RAM_READ));
    chk("midrst_ramAddress", 32'(ramAddress), 32'd0);
    chk("midrst_bDataOut", 32'(bDataOut), 32'd0);
    chk("midrst_aDataOut", 32'(aDataOut), 32'd0);
    reset = 1'b1;
    idle(1);
    fork
      do_txn(1'b0, 1'b0, 16'h0060, 16'h0000, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 16'h0070, 16'h0000, 1'b0, 1'b0);
    join
    idle(2);

    // Address change after the grant must not disturb the transaction in flight.
    ok = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("chg_grant", 32'(ok), 32'd1);
    set_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(1);
    chk("chg_addr_settle", 32'(ramAddress), 32'h0020);
    idle(1);
    chk("chg_aAck", 32'(aAck), 32'd1);
    chk("chg_aDataOut", 32'(aDataOut), 32'(init_val(16'h0020)));
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(3);

    // Randomised traffic from both clients.
    fork
      rand_client(1'b0);
      rand_client(1'b1);
    join
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
